// File: rtl/accelbrot_pkg.sv
// accelbrot_pkg: shared widths, per-item sideband record and idle-counter sizing
package accelbrot_pkg;
  localparam int TAG_W = 24;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] count;
    logic             finish;
    logic             start;
    logic             valid;
  } sideband_t;
  function automatic int idle_cnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction
endpackage

// File: rtl/accelbrot_com_delay.sv
// accelbrot_com_delay: fixed DEPTH-cycle register delay line, cleared by rst
module accelbrot_com_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam int PW = DEPTH * WIDTH;
  logic [PW-1:0] pipe_q;
  // shift one stage per cycle, newest word in the LSBs
  always_ff @(posedge clk)
    pipe_q <= rst ? '0 : PW'({pipe_q, d_i});
  assign q_o = pipe_q[PW-1 -: WIDTH];
endmodule

// File: rtl/accelbrot_loop_entry.sv
// accelbrot_loop_entry: injects pixel jobs into vacant slots of the loop ring; optional job counter under ACCELBROT_LOOP_ENTRY_STS_EN
module accelbrot_loop_entry
  import accelbrot_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int WWIDTH = 34,
  parameter int CWIDTH = 16,
  parameter int TWIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              sts_num_entered,
  input  logic [TWIDTH-1:0]        ent_tag,
  input  logic [NWORDS*WWIDTH-1:0] ent_a,
  input  logic [NWORDS*WWIDTH-1:0] ent_b,
  input  logic                     ent_valid,
  output logic                     ent_ready,
  input  logic [WWIDTH-1:0]        in_x,
  input  logic [WWIDTH-1:0]        in_y,
  input  logic [WWIDTH-1:0]        in_a,
  input  logic [WWIDTH-1:0]        in_b,
  input  logic [TWIDTH-1:0]        in_tag,
  input  logic [CWIDTH-1:0]        in_count,
  input  logic                     in_finish,
  input  logic                     in_start,
  input  logic                     in_valid,
  output logic [WWIDTH-1:0]        out_x,
  output logic [WWIDTH-1:0]        out_y,
  output logic [WWIDTH-1:0]        out_a,
  output logic [WWIDTH-1:0]        out_b,
  output logic [TWIDTH-1:0]        out_tag,
  output logic [CWIDTH-1:0]        out_count,
  output logic                     out_finish,
  output logic                     out_start,
  output logic                     out_valid
);
  localparam int IW = idle_cnt_width(NWORDS);
  localparam int RW = $clog2(NWORDS + 1);
  localparam int DW = 4 * WWIDTH + TWIDTH + CWIDTH + 3;
  logic [DW-1:0]            dly_q;
  logic [WWIDTH-1:0]        d_x, d_y, d_a, d_b;
  logic [TWIDTH-1:0]        d_tag;
  logic [CWIDTH-1:0]        d_count;
  logic                     d_finish, d_start, d_valid;
  logic                     hold_valid_q;
  logic [TWIDTH-1:0]        hold_tag_q, tag_q;
  logic [NWORDS*WWIDTH-1:0] hold_a_q, hold_b_q, a_sr_q, b_sr_q;
  logic [IW-1:0]            idle_q, idle_d;
  logic [RW-1:0]            rem_q;
  logic                     ins, window, ins_start;

  accelbrot_com_delay #(.WIDTH(DW), .DEPTH(NWORDS)) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i ({in_x, in_y, in_a, in_b, in_tag, in_count, in_finish, in_start, in_valid}),
    .q_o (dly_q)
  );
  assign {d_x, d_y, d_a, d_b, d_tag, d_count, d_finish, d_start, d_valid} = dly_q;

  assign ins       = rem_q != '0;
  assign ent_ready = !hold_valid_q;

  // a slot is free once the ring has been idle for NWORDS cycles including this one
  always_comb begin
    window    = !in_valid && idle_q == IW'(NWORDS - 1);
    ins_start = window && hold_valid_q && rem_q <= RW'(1);
    idle_d    = (in_valid || ins_start) ? '0 : (idle_q == IW'(NWORDS - 1)) ? idle_q : idle_q + 1'b1;
  end

  // holding-register flag, idle counter and serializer word count
  always_ff @(posedge clk)
    if (rst) begin
      hold_valid_q <= 1'b0;
      idle_q       <= '0;
      rem_q        <= '0;
    end else begin
      hold_valid_q <= ins_start ? 1'b0 : (ent_valid && ent_ready) ? 1'b1 : hold_valid_q;
      idle_q       <= idle_d;
      rem_q        <= ins_start ? RW'(NWORDS) : ins ? rem_q - 1'b1 : rem_q;
    end

  // job payload capture and word-serial shift-out
  always_ff @(posedge clk) begin
    if (ent_valid && ent_ready) begin
      hold_tag_q <= ent_tag;
      hold_a_q   <= ent_a;
      hold_b_q   <= ent_b;
    end
    if (ins_start) begin
      tag_q  <= hold_tag_q;
      a_sr_q <= hold_a_q;
      b_sr_q <= hold_b_q;
    end else if (ins) begin
      a_sr_q <= a_sr_q >> WWIDTH;
      b_sr_q <= b_sr_q >> WWIDTH;
    end
  end

  assign out_x      = ins ? '0 : d_x;
  assign out_y      = ins ? '0 : d_y;
  assign out_a      = ins ? a_sr_q[WWIDTH-1:0] : d_a;
  assign out_b      = ins ? b_sr_q[WWIDTH-1:0] : d_b;
  assign out_tag    = ins ? tag_q : d_tag;
  assign out_count  = ins ? '0 : d_count;
  assign out_finish = !ins && d_finish;
  assign out_start  = ins ? rem_q == RW'(NWORDS) : d_start;
  assign out_valid  = ins || d_valid;

`ifdef ACCELBROT_LOOP_ENTRY_STS_EN
  logic [31:0] sts_q;
  // count insertion starts
  always_ff @(posedge clk)
    sts_q <= rst ? '0 : sts_q + 32'(ins_start);
  assign sts_num_entered = sts_q;
`else
  assign sts_num_entered = '0;
`endif
endmodule

// File: doc/accelbrot_loop_entry.md
Name: accelbrot_loop_entry

Overview:
- Injection end of the iteration loop ring; counterpart of the loop-exit stage.
- Accepts new pixel jobs (tag, a, b) over a valid/ready port and serializes each job into a vacant NWORDS-cycle slot of the word-serial loop stream.
- Passes all circulating items through with a fixed delay.
- Sits upstream of the iteration pipeline; its input is fed by the loop-exit stage's out_* stream.

Parameters:
NWORDS, 8, words per item on the serial stream
WWIDTH, 34, bits per word
CWIDTH, 16, iteration count width
TWIDTH, 24, job tag width

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous reset, active-high
sts_num_entered  out  32  jobs inserted (see Optional Feature)
ent_tag  in  TWIDTH  job tag
ent_a  in  NWORDS*WWIDTH  real part c, word 0 in LSBs
ent_b  in  NWORDS*WWIDTH  imaginary part c, word 0 in LSBs
ent_valid  in  1  job request
ent_ready  out  1  job accept
in_x, in_y, in_a, in_b  in  WWIDTH each  loop stream words
in_tag  in  TWIDTH  item tag
in_count  in  CWIDTH  item count
in_finish, in_start, in_valid  in  1 each  item flags; in_start marks word 0
out_x, out_y, out_a, out_b  out  WWIDTH each  merged stream words
out_tag  out  TWIDTH  item tag
out_count  out  CWIDTH  item count
out_finish, out_start, out_valid  out  1 each  item flags

Behaviour:
- Passthrough: all in_* fields are delayed exactly NWORDS cycles through registers.
  - Output fields are all registered.
  - The input stream is well-formed: in_valid high for exactly NWORDS contiguous cycles starting on in_start; anything else is undefined.
- Holding register:
  - Holds one job.
  - ent_ready = !hold_valid.
  - Handshake when ent_valid && ent_ready; the job is captured on the next edge.
- Vacancy window: true in cycle t when in_valid is low at t and in the preceding NWORDS-1 cycles.
  - Track with an idle counter saturating at NWORDS-1; any in_valid clears it.
  - Starting an insertion also clears it.
- Insertion start: in a cycle where the window is true && hold_valid && not inserting.
  - Load the job into the output serializer.
  - Clear hold_valid; ent_ready is high on the next cycle.
- Insertion output, cycles t+1..t+NWORDS:
  - out_valid=1; out_start=1 on the first cycle only.
  - out_a/out_b = word k of ent_a/ent_b on cycle t+1+k.
  - out_x=out_y=0, out_count=0, out_finish=0, out_tag=job tag, held across all NWORDS cycles.
  - These cycles carry only delayed idle input by construction; the passthrough is muxed out while inserting.
- Consecutive insertions on an idle ring are contiguous: next out_start is exactly NWORDS cycles after the previous one.
- Ring fully occupied (gaps < NWORDS cycles): the job waits indefinitely and ent_ready stays low. This is legal, not an error.
- Ready/valid on ent: ent_valid may deassert only after the handshake. Data is sampled only at the handshake.
- Reset, synchronously on rst=1:
  - All outputs go to 0, hold_valid=0, idle counter=0, delay-line valid/start bits go to 0, insertion is aborted.
  - ent_ready=1 on the first cycle after rst falls.
  - Delay-line data bits need not reset.
- Minimum request-to-out_start latency on an idle ring: 2 cycles.

Optional Feature:
Macro ACCELBROT_LOOP_ENTRY_STS_EN.
- Defined: 32-bit counter increments on each insertion start, wraps at 2^32, cleared by rst; sts_num_entered is the registered copy.
- Undefined: sts_num_entered is tied to 0; no counter logic is generated.

Decomposition:
- Shared package accelbrot_pkg gains a typedef for the per-item sideband (tag, count, finish, start, valid) and a function computing the idle-counter width from NWORDS.
- One natural sub-module: the existing accelbrot_com_delay, instantiated with DEPTH=NWORDS for the word and sideband delay line.
- The serializer is inline shift logic.

Test Plan:
1. Idle ring, NWORDS=8; one job tag=0x5A, a words 1..8, b words 0x11..0x18, accepted at cycle 0:
   - out_start at cycle 2; out_valid cycles 2..9; a words 1..8 in order; x=y=count=finish=0; tag=0x5A throughout.
2. Single circulating item, start at cycle 10, no jobs:
   - Identical fields appear at cycles 18..25.
   - No insertion; ent_ready stays 1.
3. Three jobs presented back-to-back on an idle ring:
   - out_start spacing exactly 8 cycles; out_valid continuous for 24 cycles.
4. Ring items every 12 cycles (4-cycle gaps), one job pending:
   - Job never inserted; ent_ready low after first accept.
   - Widen spacing to 16: job inserted inside the gap; out_valid never overlaps a passthrough word (checked against a reference model).
5. rst asserted during the 4th word of an insertion:
   - Next cycle out_valid=0, out_start=0; after rst falls ent_ready=1; no partial item resumes.
6. With ACCELBROT_LOOP_ENTRY_STS_EN: insert 3 jobs -> sts_num_entered=3; assert rst -> 0. Without the macro it reads 0 throughout.
